// File: rtl/opb_reg_master_poller_if.sv
// OPB master-side signal bundle for opb_reg_master_poller.
// Bus vectors use OPB bit numbering: bit 0 is the most significant bit.
interface opb_reg_master_poller_if #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
);
  logic                        M_request;
  logic                        M_select;
  logic                        M_RNW;
  logic                        M_seqAddr;
  logic                        M_busLock;
  logic [0:C_OPB_AWIDTH-1]     M_ABus;
  logic [0:C_OPB_DWIDTH/8-1]   M_BE;
  logic [0:C_OPB_DWIDTH-1]     M_DBus;

  logic                        OPB_MGrant;
  logic [0:C_OPB_DWIDTH-1]     OPB_DBus;
  logic                        OPB_xferAck;
  logic                        OPB_errAck;
  logic                        OPB_retry;
  logic                        OPB_toutSup;

  modport master (
    output M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
  );

  modport slave (
    input  M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
  );
endinterface

// File: rtl/opb_reg_master_poller.sv
// Single-beat OPB register master: one user request becomes one OPB read or write,
// with bounded retries and a suppressible timeout. All outputs are registered.
module opb_reg_master_poller #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 3
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  opb_reg_master_poller_if.master   bus,
  input  logic                      user_req,
  input  logic                      user_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   user_addr,
  input  logic [C_OPB_DWIDTH/8-1:0] user_be,
  input  logic [C_OPB_DWIDTH-1:0]   user_wdata,
  output logic                      user_busy,
  output logic                      user_done,
  output logic [C_OPB_DWIDTH-1:0]   user_rdata,
  output logic [1:0]                user_err
);

  localparam int BW = C_OPB_DWIDTH / 8;
  localparam int TW = (C_TIMEOUT < 1) ? 1 : $clog2(C_TIMEOUT + 1);
  localparam int RW = (C_MAX_RETRY < 1) ? 1 : $clog2(C_MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMEOUT_V   = TW'(C_TIMEOUT);
  localparam logic [RW-1:0] MAX_RETRY_V = RW'(C_MAX_RETRY);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ERRACK  = 2'd1;
  localparam logic [1:0] ERR_RETRY   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                    state_reg, state_next;

  logic                      m_request_reg, m_request_next;
  logic                      m_select_reg,  m_select_next;
  logic                      m_rnw_reg,     m_rnw_next;
  logic [C_OPB_AWIDTH-1:0]   m_abus_reg,    m_abus_next;
  logic [BW-1:0]             m_be_reg,      m_be_next;
  logic [C_OPB_DWIDTH-1:0]   m_dbus_reg,    m_dbus_next;

  logic                      rnw_reg,       rnw_next;
  logic [C_OPB_AWIDTH-1:0]   addr_reg,      addr_next;
  logic [BW-1:0]             be_reg,        be_next;
  logic [C_OPB_DWIDTH-1:0]   wdata_reg,     wdata_next;

  logic [TW-1:0]             tout_cnt_reg,  tout_cnt_next;
  logic [RW-1:0]             retry_cnt_reg, retry_cnt_next;

  logic                      busy_reg,      busy_next;
  logic                      done_reg,      done_next;
  logic [C_OPB_DWIDTH-1:0]   rdata_reg,     rdata_next;
  logic [1:0]                err_reg,       err_next;

  logic                      finish;
  logic                      release_bus;
  logic [1:0]                finish_err;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_reg     <= IDLE;
      m_request_reg <= 1'b0;
      m_select_reg  <= 1'b0;
      m_rnw_reg     <= 1'b0;
      m_abus_reg    <= '0;
      m_be_reg      <= '0;
      m_dbus_reg    <= '0;
      rnw_reg       <= 1'b0;
      addr_reg      <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      tout_cnt_reg  <= '0;
      retry_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      m_request_reg <= m_request_next;
      m_select_reg  <= m_select_next;
      m_rnw_reg     <= m_rnw_next;
      m_abus_reg    <= m_abus_next;
      m_be_reg      <= m_be_next;
      m_dbus_reg    <= m_dbus_next;
      rnw_reg       <= rnw_next;
      addr_reg      <= addr_next;
      be_reg        <= be_next;
      wdata_reg     <= wdata_next;
      tout_cnt_reg  <= tout_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    m_request_next = m_request_reg;
    m_select_next  = m_select_reg;
    m_rnw_next     = m_rnw_reg;
    m_abus_next    = m_abus_reg;
    m_be_next      = m_be_reg;
    m_dbus_next    = m_dbus_reg;
    rnw_next       = rnw_reg;
    addr_next      = addr_reg;
    be_next        = be_reg;
    wdata_next     = wdata_reg;
    tout_cnt_next  = tout_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    finish         = 1'b0;
    release_bus    = 1'b0;
    finish_err     = ERR_NONE;

    case (state_reg)
      IDLE: begin
        if (user_req) begin
          rnw_next       = user_rnw;
          addr_next      = user_addr;
          be_next        = user_be;
          wdata_next     = user_wdata;
          tout_cnt_next  = '0;
          retry_cnt_next = '0;
          busy_next      = 1'b1;
          m_request_next = 1'b1;
          state_next     = REQ;
        end
      end

      REQ: begin
        if (bus.OPB_MGrant) begin
          m_request_next = 1'b0;
          m_select_next  = 1'b1;
          m_abus_next    = addr_reg;
          m_be_next      = be_reg;
          m_rnw_next     = rnw_reg;
          m_dbus_next    = rnw_reg ? '0 : wdata_reg;
          tout_cnt_next  = '0;
          state_next     = XFER;
        end
      end

      XFER: begin
        // Priority: errAck > xferAck > retry > timeout.
        if (bus.OPB_errAck) begin
          finish     = 1'b1;
          finish_err = ERR_ERRACK;
        end else if (bus.OPB_xferAck) begin
          finish = 1'b1;
          if (rnw_reg) begin
            rdata_next = bus.OPB_DBus;
          end
        end else if (bus.OPB_retry) begin
          if (retry_cnt_reg < MAX_RETRY_V) begin
            retry_cnt_next = retry_cnt_reg + 1'b1;
            release_bus    = 1'b1;
            m_request_next = 1'b1;
            state_next     = REQ;
          end else begin
            finish     = 1'b1;
            finish_err = ERR_RETRY;
          end
        end else if (tout_cnt_reg == TIMEOUT_V) begin
          finish     = 1'b1;
          finish_err = ERR_TIMEOUT;
        end else if (!bus.OPB_toutSup) begin
          tout_cnt_next = tout_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish) begin
      release_bus = 1'b1;
      done_next   = 1'b1;
      busy_next   = 1'b0;
      err_next    = finish_err;
      state_next  = IDLE;
    end

    // Deselected master must drive zeros onto the OR-combined OPB buses.
    if (release_bus) begin
      m_select_next = 1'b0;
      m_rnw_next    = 1'b0;
      m_abus_next   = '0;
      m_be_next     = '0;
      m_dbus_next   = '0;
    end
  end

  assign bus.M_request = m_request_reg;
  assign bus.M_select  = m_select_reg;
  assign bus.M_RNW     = m_rnw_reg;
  assign bus.M_seqAddr = 1'b0;
  assign bus.M_busLock = 1'b0;
  assign bus.M_ABus    = m_abus_reg;
  assign bus.M_BE      = m_be_reg;
  assign bus.M_DBus    = m_dbus_reg;

  assign user_busy  = busy_reg;
  assign user_done  = done_reg;
  assign user_rdata = rdata_reg;
  assign user_err   = err_reg;

endmodule

// File: tb/tb_opb_reg_master_poller.sv
// Randomised self-checking bench: a behavioural OPB slave answers each transfer from a
// per-attempt plan, and a cycle-arithmetic model predicts the user-side outcome.
module tb_opb_reg_master_poller;

  localparam int TO     = 16;
  localparam int MR     = 3;
  localparam int MAXCYC = 400;

  localparam int K_ACK       = 0;
  localparam int K_ERR       = 1;
  localparam int K_RETRY     = 2;
  localparam int K_NONE      = 3;
  localparam int K_ACK_ERR   = 4;
  localparam int K_ACK_RETRY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        user_req;
  logic        user_rnw;
  logic [31:0] user_addr;
  logic [3:0]  user_be;
  logic [31:0] user_wdata;
  logic        user_busy;
  logic        user_done;
  logic [31:0] user_rdata;
  logic [1:0]  user_err;

  always #5 clk = ~clk;

  opb_reg_master_poller_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus ();

  opb_reg_master_poller #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TIMEOUT(TO), .C_MAX_RETRY(MR)
  ) dut (
    .OPB_Clk   (clk),
    .OPB_Rst   (rst),
    .bus       (bus.master),
    .user_req  (user_req),
    .user_rnw  (user_rnw),
    .user_addr (user_addr),
    .user_be   (user_be),
    .user_wdata(user_wdata),
    .user_busy (user_busy),
    .user_done (user_done),
    .user_rdata(user_rdata),
    .user_err  (user_err)
  );

  logic [108:0] all_out;
  assign all_out = {user_busy, user_done, user_rdata, user_err,
                    bus.M_request, bus.M_select, bus.M_RNW, bus.M_seqAddr, bus.M_busLock,
                    bus.M_ABus, bus.M_BE, bus.M_DBus};

  int vectors = 0;
  int miscompares = 0;

  // per-attempt slave plan
  int          p_grant[4];
  int          p_resp[4];
  int          p_kind[4];
  int          p_tsup[4];
  logic [31:0] p_data[4];

  logic        t_rnw;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  bit          t_noise;

  int          o_done_cycle, o_sel_start, o_phases, o_req_phases, o_req_cycles;
  int          o_bus_bad, o_busy_bad;
  logic [1:0]  o_err;
  logic [31:0] o_rdata;
  bit          o_hung;

  int          e_done_cycle, e_sel_start, e_phases, e_req_phases, e_req_cycles;
  logic [1:0]  e_err;
  logic [31:0] e_rdata;
  logic [31:0] model_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      p_grant[i] = 1;
      p_resp[i]  = 0;
      p_kind[i]  = K_ACK;
      p_tsup[i]  = 0;
      p_data[i]  = $urandom;
    end
  endtask

  task automatic set_txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input bit noise);
    t_rnw   = rnw;
    t_addr  = addr;
    t_be    = be;
    t_wdata = wdata;
    t_noise = noise;
  endtask

  // Outcome predicted from the protocol rules: cycle 0 = user_req, request rises at 1,
  // select follows the grant, a response at select-cycle k ends the phase at k+1.
  task automatic model_xfer();
    int t, sel, lim, att, retries;
    bit fin;
    t = 1; att = 0; retries = 0; fin = 0;
    e_phases = 0; e_req_phases = 0; e_req_cycles = 0; e_sel_start = 0; e_done_cycle = 0;
    e_rdata = model_rdata; e_err = 2'd0;
    while (!fin) begin
      e_req_phases++;
      e_req_cycles += p_grant[att];
      sel = t + p_grant[att];
      if (att == 0) e_sel_start = sel;
      e_phases++;
      lim = TO + p_tsup[att];
      if (p_kind[att] == K_NONE || p_resp[att] > lim) begin
        e_done_cycle = sel + lim + 1;
        e_err = 2'd3;
        fin = 1;
      end else begin
        e_done_cycle = sel + p_resp[att] + 1;
        case (p_kind[att])
          K_ERR, K_ACK_ERR: begin e_err = 2'd1; fin = 1; end
          K_RETRY: begin
            if (retries < MR) begin
              retries++;
              t = e_done_cycle;
              att++;
            end else begin
              e_err = 2'd2;
              fin = 1;
            end
          end
          default: begin
            e_err = 2'd0;
            if (t_rnw) e_rdata = p_data[att];
            fin = 1;
          end
        endcase
      end
    end
  endtask

  // Issues one user request and plays the OPB slave until user_done or the cycle budget.
  task automatic drive_xfer();
    int cyc, att, req_run, sel_run;
    bit prev_sel, prev_req, fin;
    o_done_cycle = -1; o_sel_start = -1; o_phases = 0; o_req_phases = 0; o_req_cycles = 0;
    o_bus_bad = 0; o_busy_bad = 0; o_err = 2'd0; o_rdata = 32'h0; o_hung = 0;
    user_req = 1'b1; user_rnw = t_rnw; user_addr = t_addr; user_be = t_be; user_wdata = t_wdata;
    cyc = 0; att = 0; req_run = 0; sel_run = 0; prev_sel = 0; prev_req = 0; fin = 0;
    while (!fin && cyc < MAXCYC) begin
      tick();
      cyc++;
      bus.OPB_MGrant = 1'b0; bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0;
      bus.OPB_retry = 1'b0; bus.OPB_toutSup = 1'b0; bus.OPB_DBus = $urandom;
      if (t_noise) begin
        user_req = 1'($urandom_range(0, 1)); user_rnw = 1'($urandom_range(0, 1));
        user_addr = $urandom; user_be = 4'($urandom); user_wdata = $urandom;
      end else begin
        user_req = 1'b0;
      end
      if (bus.M_request && !prev_req) o_req_phases++;
      if (bus.M_request) o_req_cycles++;
      if (bus.M_seqAddr || bus.M_busLock || (bus.M_request && bus.M_select)) o_bus_bad++;
      if (!bus.M_select) begin
        if (bus.M_ABus != 0 || bus.M_BE != 0 || bus.M_DBus != 0 || bus.M_RNW) o_bus_bad++;
      end else if (bus.M_ABus !== t_addr || bus.M_BE !== t_be || bus.M_RNW !== t_rnw ||
                   bus.M_DBus !== (t_rnw ? 32'h0 : t_wdata)) begin
        o_bus_bad++;
      end
      if (user_busy === user_done) o_busy_bad++;
      if (!bus.M_select && prev_sel && att < 3) att++;
      if (user_done) begin
        fin = 1;
        o_done_cycle = cyc;
        o_err = user_err;
        o_rdata = user_rdata;
        user_req = 1'b0;
      end else begin
        if (bus.M_request) begin
          req_run++;
          if (req_run >= p_grant[att]) bus.OPB_MGrant = 1'b1;
        end else begin
          req_run = 0;
        end
        if (bus.M_select) begin
          if (!prev_sel) begin
            o_phases++;
            sel_run = 0;
            if (o_phases == 1) o_sel_start = cyc;
          end
          if (sel_run < p_tsup[att]) bus.OPB_toutSup = 1'b1;
          if (sel_run == p_resp[att]) begin
            case (p_kind[att])
              K_ACK:       begin bus.OPB_xferAck = 1'b1; bus.OPB_DBus = p_data[att]; end
              K_ERR:       bus.OPB_errAck = 1'b1;
              K_RETRY:     bus.OPB_retry = 1'b1;
              K_ACK_ERR:   begin bus.OPB_xferAck = 1'b1; bus.OPB_errAck = 1'b1; end
              K_ACK_RETRY: begin bus.OPB_xferAck = 1'b1; bus.OPB_retry = 1'b1; bus.OPB_DBus = p_data[att]; end
              default:     ;
            endcase
          end
          sel_run++;
        end
      end
      prev_sel = bus.M_select;
      prev_req = bus.M_request;
    end
    o_hung = !fin;
    user_req = 1'b0;
    bus.OPB_MGrant = 1'b0; bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0;
    bus.OPB_retry = 1'b0; bus.OPB_toutSup = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    user_req = 1'b1; user_rnw = 1'b1; user_addr = 32'hFFFF_FFFF; user_be = 4'hF; user_wdata = 32'h1;
    bus.OPB_MGrant = 1'b1; bus.OPB_DBus = 32'hFFFF_FFFF; bus.OPB_xferAck = 1'b1;
    bus.OPB_errAck = 1'b0; bus.OPB_retry = 1'b0; bus.OPB_toutSup = 1'b0;
    tick(); tick();
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, need 0", all_out);
    end
    user_req = 1'b0; bus.OPB_MGrant = 1'b0; bus.OPB_xferAck = 1'b0; bus.OPB_DBus = 32'h0;
    rst = 1'b0;
    model_rdata = 32'h0;
    $display("reset: outputs %h", all_out);
  endtask

  task automatic test_read_basic();
    clear_plan();
    p_data[0] = 32'hDEADBEEF;
    set_txn(1'b1, 32'h01060E00, 4'hF, 32'h0, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_done_cycle !== 3) begin miscompares++; $display("FAIL read_done_cycle: got %0d, need 3", o_done_cycle); end
    vectors++;
    if (o_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rdata: got %h, need deadbeef", o_rdata); end
    vectors++;
    if (o_err !== 2'd0) begin miscompares++; $display("FAIL read_err: got %0d, need 0", o_err); end
    vectors++;
    if (o_bus_bad !== 0 || o_busy_bad !== 0) begin
      miscompares++; $display("FAIL read_bus_rules: bus %0d busy %0d violations, need 0", o_bus_bad, o_busy_bad);
    end
    model_rdata = e_rdata;
    $display("read_basic: done@%0d rdata=%h err=%0d", o_done_cycle, o_rdata, o_err);
  endtask

  task automatic test_write_grant_delay();
    clear_plan();
    p_grant[0] = 5;
    set_txn(1'b0, $urandom, 4'hF, 32'h12345678, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_req_cycles !== 5) begin miscompares++; $display("FAIL write_request_cycles: got %0d, need 5", o_req_cycles); end
    vectors++;
    if (o_bus_bad !== 0) begin miscompares++; $display("FAIL write_dbus_rule: got %0d violations, need 0", o_bus_bad); end
    vectors++;
    if (o_err !== 2'd0 || o_rdata !== e_rdata) begin
      miscompares++; $display("FAIL write_result: got err %0d rdata %h, need err 0 rdata %h", o_err, o_rdata, e_rdata);
    end
    vectors++;
    if (o_done_cycle !== e_done_cycle) begin
      miscompares++; $display("FAIL write_done_cycle: got %0d, need %0d", o_done_cycle, e_done_cycle);
    end
    model_rdata = e_rdata;
    $display("write_grant_delay: req_cycles=%0d done@%0d err=%0d", o_req_cycles, o_done_cycle, o_err);
  endtask

  task automatic test_retry_limit();
    clear_plan();
    for (int i = 0; i < 4; i++) begin
      p_kind[i] = K_RETRY;
      p_resp[i] = $urandom_range(0, 2);
    end
    set_txn(1'b1, $urandom, 4'hF, 32'h0, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_phases !== 4 || o_req_phases !== 4) begin
      miscompares++; $display("FAIL retry_phases: got sel %0d req %0d, need 4 and 4", o_phases, o_req_phases);
    end
    vectors++;
    if (o_err !== 2'd2) begin miscompares++; $display("FAIL retry_err: got %0d, need 2", o_err); end
    vectors++;
    if (o_done_cycle !== e_done_cycle || o_rdata !== e_rdata) begin
      miscompares++;
      $display("FAIL retry_done: got @%0d rdata %h, need @%0d rdata %h", o_done_cycle, o_rdata, e_done_cycle, e_rdata);
    end
    model_rdata = e_rdata;
    $display("retry_limit: phases=%0d done@%0d err=%0d", o_phases, o_done_cycle, o_err);
  endtask

  task automatic test_timeout();
    int need[2];
    need[0] = 17;
    need[1] = 27;
    for (int r = 0; r < 2; r++) begin
      clear_plan();
      p_kind[0] = K_NONE;
      p_tsup[0] = (r == 0) ? 0 : 10;
      set_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, 0);
      model_xfer();
      drive_xfer();
      vectors++;
      if (o_done_cycle - o_sel_start !== need[r] || o_hung) begin
        miscompares++;
        $display("FAIL timeout_latency: got %0d cycles, need %0d", o_done_cycle - o_sel_start, need[r]);
      end
      vectors++;
      if (o_err !== 2'd3 || o_rdata !== e_rdata) begin
        miscompares++; $display("FAIL timeout_err: got err %0d rdata %h, need 3 and %h", o_err, o_rdata, e_rdata);
      end
      model_rdata = e_rdata;
      $display("timeout: toutSup=%0d latency=%0d err=%0d", p_tsup[0], o_done_cycle - o_sel_start, o_err);
    end
  endtask

  task automatic test_priority();
    clear_plan();
    p_kind[0] = K_ACK_ERR;
    set_txn(1'b1, $urandom, 4'hF, 32'h0, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_err !== 2'd1 || o_rdata !== e_rdata) begin
      miscompares++; $display("FAIL prio_err_over_ack: got err %0d rdata %h, need 1 and %h", o_err, o_rdata, e_rdata);
    end
    model_rdata = e_rdata;
    $display("priority errAck+xferAck: err=%0d", o_err);

    clear_plan();
    p_kind[0] = K_ACK_RETRY;
    p_resp[0] = 2;
    set_txn(1'b1, $urandom, 4'h3, 32'h0, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_err !== 2'd0 || o_rdata !== p_data[0]) begin
      miscompares++; $display("FAIL prio_ack_over_retry: got err %0d rdata %h, need 0 and %h", o_err, o_rdata, p_data[0]);
    end
    vectors++;
    if (o_req_phases !== 1 || o_phases !== 1) begin
      miscompares++; $display("FAIL prio_no_rerequest: got req %0d sel %0d phases, need 1 and 1", o_req_phases, o_phases);
    end
    model_rdata = e_rdata;
    $display("priority xferAck+retry: err=%0d req_phases=%0d", o_err, o_req_phases);
  endtask

  task automatic test_busy_ignore();
    clear_plan();
    p_grant[0] = 2;
    p_resp[0]  = 3;
    set_txn(1'b0, $urandom, 4'($urandom), $urandom, 1);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_bus_bad !== 0 || o_done_cycle !== e_done_cycle) begin
      miscompares++;
      $display("FAIL busy_no_relatch: got %0d bus violations done@%0d, need 0 and @%0d", o_bus_bad, o_done_cycle, e_done_cycle);
    end
    tick();
    vectors++;
    if (user_done !== 1'b0 || bus.M_request !== 1'b0 || user_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_no_queue: got done %b req %b busy %b, need 0 0 0", user_done, bus.M_request, user_busy);
    end
    model_rdata = e_rdata;
    $display("busy_ignore: done@%0d err=%0d", o_done_cycle, o_err);
  endtask

  task automatic test_reset_mid_xfer();
    int seen_done;
    user_req = 1'b1; user_rnw = 1'b1; user_addr = 32'hA5A5_0000; user_be = 4'hF; user_wdata = 32'h0;
    tick();
    user_req = 1'b0;
    bus.OPB_MGrant = 1'b1;
    tick();
    bus.OPB_MGrant = 1'b0;
    vectors++;
    if (bus.M_select !== 1'b1) begin miscompares++; $display("FAIL rst_mid_setup: got select %b, need 1", bus.M_select); end
    bus.OPB_xferAck = 1'b1;
    bus.OPB_DBus = 32'hCAFE_F00D;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (all_out !== '0) begin miscompares++; $display("FAIL rst_mid_outputs: got %h, need 0", all_out); end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (user_done !== 1'b0) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d done pulses, need 0", seen_done); end
    bus.OPB_xferAck = 1'b0;
    rst = 1'b0;
    model_rdata = 32'h0;
    clear_plan();
    set_txn(1'b1, $urandom, 4'hF, 32'h0, 0);
    model_xfer();
    drive_xfer();
    vectors++;
    if (o_done_cycle !== 3 || o_rdata !== p_data[0] || o_err !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_recover: got @%0d rdata %h err %0d, need @3 rdata %h err 0", o_done_cycle, o_rdata, o_err, p_data[0]);
    end
    model_rdata = e_rdata;
    $display("reset_mid_xfer: recovery done@%0d rdata=%h", o_done_cycle, o_rdata);
  endtask

  task automatic test_random_back_to_back();
    int r;
    for (int n = 0; n < 30; n++) begin
      clear_plan();
      for (int i = 0; i < 4; i++) begin
        p_grant[i] = $urandom_range(1, 4);
        p_resp[i]  = $urandom_range(0, 6);
        p_tsup[i]  = $urandom_range(0, 3);
        r = $urandom_range(0, 9);
        p_kind[i] = (r < 4) ? K_ACK : (r == 4) ? K_ERR : (r < 7) ? K_RETRY :
                    (r == 7) ? K_NONE : (r == 8) ? K_ACK_ERR : K_ACK_RETRY;
      end
      set_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, bit'($urandom_range(0, 1)));
      model_xfer();
      drive_xfer();
      vectors++;
      if (o_done_cycle !== e_done_cycle || o_hung) begin
        miscompares++; $display("FAIL rand%0d_done_cycle: got %0d, need %0d", n, o_done_cycle, e_done_cycle);
      end
      vectors++;
      if (o_err !== e_err) begin miscompares++; $display("FAIL rand%0d_err: got %0d, need %0d", n, o_err, e_err); end
      vectors++;
      if (o_rdata !== e_rdata) begin miscompares++; $display("FAIL rand%0d_rdata: got %h, need %h", n, o_rdata, e_rdata); end
      vectors++;
      if (o_phases !== e_phases || o_req_cycles !== e_req_cycles || o_req_phases !== e_req_phases) begin
        miscompares++;
        $display("FAIL rand%0d_phases: got sel %0d req %0d/%0d cyc, need %0d %0d/%0d",
                 n, o_phases, o_req_phases, o_req_cycles, e_phases, e_req_phases, e_req_cycles);
      end
      vectors++;
      if (o_bus_bad !== 0 || o_busy_bad !== 0) begin
        miscompares++; $display("FAIL rand%0d_bus_rules: got bus %0d busy %0d violations, need 0", n, o_bus_bad, o_busy_bad);
      end
      model_rdata = e_rdata;
      $display("rand%0d: rnw=%b done@%0d err=%0d rdata=%h", n, t_rnw, o_done_cycle, o_err, o_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_grant_delay();
    test_retry_limit();
    test_timeout();
    test_priority();
    test_busy_ignore();
    test_reset_mid_xfer();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/opb_reg_master_poller.md
OPB_REG_MASTER_POLLER -- requirements
Module: opb_reg_master_poller

Interface
REQ-001 The block SHALL have parameters C_OPB_AWIDTH, default 32, address width; C_OPB_DWIDTH, default 32, data width.
REQ-002 The block SHALL have parameters C_TIMEOUT, default 16, wait cycles before abort; C_MAX_RETRY, default 3, retries before abort.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: OPB_Clk in 1, sole clock; OPB_Rst in 1, active-high asynchronous reset.
REQ-004 The block SHALL have OPB master outputs: M_request out 1; M_select out 1; M_RNW out 1; M_seqAddr out 1, tied 0; M_busLock out 1, tied 0; M_ABus out [0:31]; M_BE out [0:3]; M_DBus out [0:31].
REQ-005 The block SHALL have OPB inputs: OPB_MGrant in 1; OPB_DBus in [0:31]; OPB_xferAck in 1; OPB_errAck in 1; OPB_retry in 1; OPB_toutSup in 1.
REQ-006 The block SHALL have user ports: user_req in 1, start pulse; user_rnw in 1, 1=read; user_addr in 32; user_be in 4; user_wdata in 32; user_busy out 1; user_done out 1, one-cycle pulse; user_rdata out 32; user_err out 2.

Function
REQ-007 All outputs SHALL be registered; FSM states: IDLE, REQ, XFER.
REQ-008 In IDLE, user_req=1 SHALL latch addr/be/rnw/wdata, clear retry and timeout counters, set user_busy=1 and M_request=1 next cycle, and enter REQ.
REQ-009 user_req while user_busy=1 SHALL be ignored, with no latch or queue.
REQ-010 In REQ, M_request SHALL stay 1 until OPB_MGrant=1 is sampled; the next cycle M_request=0, M_select=1, M_ABus/M_BE/M_RNW drive the latched values, and the state is XFER.
REQ-011 When M_select=0, M_ABus, M_BE, M_DBus and M_RNW SHALL be 0 (OR-bus rule); M_DBus SHALL be nonzero only in XFER with M_RNW=0.
REQ-012 In XFER, OPB_xferAck=1 without errAck SHALL, next cycle: M_select=0, user_done=1, user_err=0, user_rdata=OPB_DBus sampled at ack if read (unchanged if write), user_busy=0, state IDLE.
REQ-013 In XFER, OPB_errAck=1 SHALL end the transfer as in REQ-012 with user_err=1 and user_rdata unchanged; errAck SHALL win over simultaneous xferAck.
REQ-014 In XFER, OPB_retry=1 without xferAck SHALL drop M_select next cycle and increment the retry count; if count<C_MAX_RETRY, return to REQ with M_request=1; else end with user_err=2.
REQ-015 xferAck SHALL take priority over a simultaneous retry.
REQ-016 The timeout counter SHALL increment each XFER cycle with no ack/retry and OPB_toutSup=0, hold while OPB_toutSup=1, and reset on entry to XFER.
REQ-017 When the timeout count reaches C_TIMEOUT, the transfer SHALL end with user_err=3.
REQ-018 Minimum latency SHALL be: user_req at cycle 0, M_request at 1, MGrant sampled at 1, M_select at 2, xferAck at 2, user_done at 3.
REQ-019 user_rdata and user_err SHALL hold until the next user_done.
REQ-020 Counter widths SHALL be ceil(log2(param+1)) with no wrap; a retry count at C_MAX_RETRY SHALL never increment further.

Reset
REQ-021 OPB_Rst=1 SHALL asynchronously force state IDLE, all outputs 0, and all counters and latches 0, including mid-transfer.
REQ-022 After reset deassertion, the first user_req SHALL be accepted on the first rising edge.
REQ-023 An aborted transfer SHALL produce no user_done pulse.

Verification
REQ-024 Bench SHALL check: read addr 0x01060E00, MGrant immediate, xferAck with OPB_DBus=0xDEADBEEF at cycle 2 -> user_done at cycle 3, user_rdata=0xDEADBEEF, user_err=0.
REQ-025 Bench SHALL check: write wdata 0x12345678, be 0xF, MGrant delayed 5 cycles -> M_request high 5 cycles, M_DBus=0x12345678 only while M_select=1, user_err=0.
REQ-026 Bench SHALL check: OPB_retry on 4 consecutive attempts with C_MAX_RETRY=3 -> 4 select phases, then user_done with user_err=2.
REQ-027 Bench SHALL check: no ack, toutSup=0, C_TIMEOUT=16 -> user_done 17 cycles after M_select rises, user_err=3; with toutSup high 10 cycles -> 27 cycles.
REQ-028 Bench SHALL check: xferAck and errAck in the same cycle -> user_err=1; xferAck and retry in the same cycle -> user_err=0 and no re-request.
REQ-029 Bench SHALL check: OPB_Rst asserted mid-XFER -> all outputs 0 within the same cycle, no user_done, and a new read after release completes normally.
